// File: rtl/fp_divider_if.sv
// ============================================================================
// Module      : fp_divider_if
// Description : Start/busy/done handshake and operand/result bundle for fp_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fp_divider_if;
    logic        start;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] quot;
    logic        exception;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    modport master (
        output start, A, B,
        input  busy, done, quot, exception, overflow, underflow, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output busy, done, quot, exception, overflow, underflow, div_by_zero
    );
endinterface

`default_nettype wire

// File: rtl/fp_divider.sv
// ============================================================================
// Module      : fp_divider
// Description : Iterative IEEE-754 single-precision divider, one quotient bit
//               per cycle, truncating, with multiplier-style flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fp_divider (
    input  logic         clk,
    input  logic         reset,
    fp_divider_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_NORM   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic        r_exc;
    logic        r_dbz;
    logic        r_azero;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [24:0] r_q;
    logic [4:0]  r_count;

    logic [31:0] r_quot;
    logic        r_exception;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_div_by_zero;

    logic [7:0]  w_ea;
    logic [7:0]  w_eb;
    logic        w_a_zero;
    logic        w_b_zero;
    logic        w_exc;
    logic        w_dbz;
    logic        w_special;
    logic [25:0] w_trial;
    logic        w_trial_neg;
    logic [24:0] w_rem_sel;
    logic signed [9:0] w_e;
    logic        w_ovf;
    logic        w_unf;
    logic [22:0] w_frac;

    // Operand classification; denormals are treated as zero.
    assign w_ea      = bus.A[30:23];
    assign w_eb      = bus.B[30:23];
    assign w_a_zero  = (w_ea == 8'd0);
    assign w_b_zero  = (w_eb == 8'd0);
    assign w_exc     = (w_ea == 8'hFF) || (w_eb == 8'hFF) || (w_a_zero && w_b_zero);
    assign w_dbz     = !w_exc && w_b_zero && !w_a_zero;
    assign w_special = w_exc || w_dbz || w_a_zero;

    // Remainder stays below 2*mB, so 25 bits hold it and 26 bits hold the trial.
    assign w_trial     = {1'b0, r_rem} - {2'b00, r_mb};
    assign w_trial_neg = w_trial[25];
    assign w_rem_sel   = w_trial_neg ? r_rem : w_trial[24:0];

    assign w_e    = $signed({2'b00, r_ea}) - $signed({2'b00, r_eb})
                  + (r_q[24] ? 10'sd127 : 10'sd126);
    assign w_ovf  = (w_e >= 10'sd255);
    assign w_unf  = (w_e <= 10'sd0);
    assign w_frac = r_q[24] ? r_q[23:1] : r_q[22:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.start) w_next = w_special ? S_NORM : S_DIVIDE;
            S_DIVIDE: if (r_count == 5'd24) w_next = S_NORM;
            S_NORM:   w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sign        <= 1'b0;
            r_ea          <= 8'd0;
            r_eb          <= 8'd0;
            r_exc         <= 1'b0;
            r_dbz         <= 1'b0;
            r_azero       <= 1'b0;
            r_mb          <= 24'd0;
            r_rem         <= 25'd0;
            r_q           <= 25'd0;
            r_count       <= 5'd0;
            r_quot        <= 32'd0;
            r_exception   <= 1'b0;
            r_overflow    <= 1'b0;
            r_underflow   <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sign        <= bus.A[31] ^ bus.B[31];
                        r_ea          <= w_ea;
                        r_eb          <= w_eb;
                        r_exc         <= w_exc;
                        r_dbz         <= w_dbz;
                        r_azero       <= w_a_zero;
                        r_mb          <= {1'b1, bus.B[22:0]};
                        r_rem         <= {2'b01, bus.A[22:0]};
                        r_q           <= 25'd0;
                        r_count       <= 5'd0;
                        r_exception   <= 1'b0;
                        r_overflow    <= 1'b0;
                        r_underflow   <= 1'b0;
                        r_div_by_zero <= 1'b0;
                    end
                end
                S_DIVIDE: begin
                    r_q     <= {r_q[23:0], ~w_trial_neg};
                    r_rem   <= w_rem_sel << 1;
                    r_count <= r_count + 5'd1;
                end
                S_NORM: begin
                    if (r_exc) begin
                        r_quot      <= 32'd0;
                        r_exception <= 1'b1;
                    end else if (r_dbz) begin
                        r_quot        <= {r_sign, 8'hFF, 23'd0};
                        r_div_by_zero <= 1'b1;
                    end else if (r_azero) begin
                        r_quot <= {r_sign, 31'd0};
                    end else if (w_ovf) begin
                        r_quot     <= {r_sign, 8'hFF, 23'd0};
                        r_overflow <= 1'b1;
                    end else if (w_unf) begin
                        r_quot      <= {r_sign, 31'd0};
                        r_underflow <= 1'b1;
                    end else begin
                        r_quot <= {r_sign, w_e[7:0], w_frac};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.quot        = r_quot;
    assign bus.exception   = r_exception;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

`default_nettype wire

// File: tb/tb_fp_divider.sv
// ============================================================================
// Module      : tb_fp_divider
// Description : Directed self-checking bench for fp_divider.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fp_divider;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    fp_divider_if bus ();

    fp_divider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launches one operation from IDLE; lat is the edge count from acceptance to done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        bus.A     = a;
        bus.B     = b;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            failures++;
            $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done});
        end
        checks++;
        if (bus.quot !== 32'd0) begin
            failures++;
            $display("FAIL reset_quot: got %h expected 00000000", bus.quot);
        end
        checks++;
        if ({bus.exception, bus.overflow, bus.underflow, bus.div_by_zero} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000",
                     {bus.exception, bus.overflow, bus.underflow, bus.div_by_zero});
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    // Table-driven arithmetic cases; flags are {exception, overflow, underflow, div_by_zero}.
    task automatic test_arith(input string name, input int n,
                              input logic [31:0] va [8], input logic [31:0] vb [8],
                              input logic [31:0] vq [8], input logic [3:0] vf [8],
                              input int vl [8]);
        int lat;
        for (int i = 0; i < n; i++) begin
            run_op(va[i], vb[i], lat);
            checks++;
            if (lat !== vl[i]) begin
                failures++;
                $display("FAIL %s[%0d]_latency: got %0d expected %0d", name, i, lat, vl[i]);
            end
            checks++;
            if (bus.quot !== vq[i]) begin
                failures++;
                $display("FAIL %s[%0d]_quot: got %h expected %h", name, i, bus.quot, vq[i]);
            end
            checks++;
            if ({bus.exception, bus.overflow, bus.underflow, bus.div_by_zero} !== vf[i]) begin
                failures++;
                $display("FAIL %s[%0d]_flags: got %b expected %b", name, i,
                         {bus.exception, bus.overflow, bus.underflow, bus.div_by_zero}, vf[i]);
            end
            @(posedge clk); #1;
            checks++;
            if ({bus.busy, bus.done, bus.quot} !== {2'b00, vq[i]}) begin
                failures++;
                $display("FAIL %s[%0d]_hold: got busy=%b done=%b quot=%h expected 0 0 %h",
                         name, i, bus.busy, bus.done, bus.quot, vq[i]);
            end
        end
    endtask

    task automatic test_normal();
        logic [31:0] va [8] = '{32'h40400000, 32'h3F800000, 32'hBF800000, 32'h40A00000, 0, 0, 0, 0};
        logic [31:0] vb [8] = '{32'h3FC00000, 32'h40400000, 32'h3F800000, 32'h40000000, 0, 0, 0, 0};
        logic [31:0] vq [8] = '{32'h40000000, 32'h3EAAAAAA, 32'hBF800000, 32'h40200000, 0, 0, 0, 0};
        logic [3:0]  vf [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
        int          vl [8] = '{26, 26, 26, 26, 0, 0, 0, 0};
        test_arith("normal", 4, va, vb, vq, vf, vl);
    endtask

    task automatic test_special();
        logic [31:0] va [8] = '{32'hC0000000, 32'h00000000, 32'h80000000, 32'h7F800000, 0, 0, 0, 0};
        logic [31:0] vb [8] = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h3F800000, 0, 0, 0, 0};
        logic [31:0] vq [8] = '{32'hFF800000, 32'h00000000, 32'h80000000, 32'h00000000, 0, 0, 0, 0};
        logic [3:0]  vf [8] = '{4'b0001, 4'b1000, 4'b0000, 4'b1000, 0, 0, 0, 0};
        int          vl [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        test_arith("special", 4, va, vb, vq, vf, vl);
    endtask

    task automatic test_range();
        logic [31:0] va [8] = '{32'h7F000000, 32'h00800000, 0, 0, 0, 0, 0, 0};
        logic [31:0] vb [8] = '{32'h00800000, 32'h7F000000, 0, 0, 0, 0, 0, 0};
        logic [31:0] vq [8] = '{32'h7F800000, 32'h00000000, 0, 0, 0, 0, 0, 0};
        logic [3:0]  vf [8] = '{4'b0100, 4'b0010, 0, 0, 0, 0, 0, 0};
        int          vl [8] = '{26, 26, 0, 0, 0, 0, 0, 0};
        test_arith("range", 2, va, vb, vq, vf, vl);
    endtask

    task automatic test_ignore_start();
        int lat = -1;
        bus.A = 32'h40400000; bus.B = 32'h3FC00000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                lat = k;
                // A start during the DONE cycle must also be ignored.
                bus.A = 32'h40A00000; bus.B = 32'h40000000; bus.start = 1'b1;
                break;
            end
            if (k == 4) begin
                bus.A = 32'h3F800000; bus.B = 32'h40400000; bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
                if (k > 4) begin
                    bus.A = $urandom;
                    bus.B = $urandom;
                end
            end
        end
        checks++;
        if (lat !== 26) begin
            failures++;
            $display("FAIL ignore_latency: got %0d expected 26", lat);
        end
        checks++;
        if (bus.quot !== 32'h40000000) begin
            failures++;
            $display("FAIL ignore_quot: got %h expected 40000000", bus.quot);
        end
        @(posedge clk); #1;
        bus.start = 1'b0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_done_cycle_start: got busy=%b expected 0", bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int          n = 0;
        int          d [2] = '{-1, -1};
        logic [31:0] q [2] = '{32'd0, 32'd0};
        bus.A = 32'h40400000; bus.B = 32'h3FC00000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.A = 32'h3F800000; bus.B = 32'h40400000;
        for (int k = 1; k <= 70 && n < 2; k++) begin
            @(posedge clk); #1;
            if (bus.done) begin
                d[n] = k;
                q[n] = bus.quot;
                n++;
            end
        end
        bus.start = 1'b0;
        checks++;
        if ({d[0], d[1]} !== {32'sd26, 32'sd54}) begin
            failures++;
            $display("FAIL b2b_done_edges: got %0d,%0d expected 26,54", d[0], d[1]);
        end
        checks++;
        if ({q[0], q[1]} !== {32'h40000000, 32'h3EAAAAAA}) begin
            failures++;
            $display("FAIL b2b_quot: got %h,%h expected 40000000,3EAAAAAA", q[0], q[1]);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int lat;
        int spurious = 0;
        bus.A = 32'h40400000; bus.B = 32'h3FC00000; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if ({bus.busy, bus.done, bus.quot} !== 34'd0) begin
            failures++;
            $display("FAIL abort_state: got busy=%b done=%b quot=%h expected 0 0 00000000",
                     bus.busy, bus.done, bus.quot);
        end
        checks++;
        if ({bus.exception, bus.overflow, bus.underflow, bus.div_by_zero} !== 4'b0000) begin
            failures++;
            $display("FAIL abort_flags: got %b expected 0000",
                     {bus.exception, bus.overflow, bus.underflow, bus.div_by_zero});
        end
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL abort_no_done: got %0d busy/done cycles expected 0", spurious);
        end
        run_op(32'h40A00000, 32'h40000000, lat);
        checks++;
        if ({lat, bus.quot} !== {32'sd26, 32'h40200000}) begin
            failures++;
            $display("FAIL abort_restart: got lat=%0d quot=%h expected 26 40200000", lat, bus.quot);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 32'd0;
        bus.B     = 32'd0;
        test_reset();
        test_normal();
        test_special();
        test_range();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/fp_divider.md
Name: fp_divider

Overview:
- Iterative IEEE-754 single-precision divider, the inverse-direction companion to the team's combinational FP multiplier.
- Used by the MLP datapath for normalisation and scaling steps.
- Computes quot = A / B with a restoring mantissa divider that produces one quotient bit per cycle.
- Uses a start/busy/done handshake.
- Exception, overflow and underflow reporting matches the multiplier's flag conventions, plus a divide-by-zero flag.

Parameters:
- None. The format is fixed at 32-bit single precision: 8-bit exponent, bias 127, 23-bit fraction.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  32  dividend, captured on the accepted start.
- B  input  32  divisor, captured on the accepted start.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse; result outputs are valid from this cycle on.
- quot  output  32  result.
- exception  output  1  an operand had exponent 8'hFF, or the operation was 0/0.
- overflow  output  1  result exponent >= 255.
- underflow  output  1  result exponent <= 0.
- div_by_zero  output  1  B is zero and A is nonzero and finite.

Behaviour:
- Reset: state=IDLE; busy, done, quot, exception, overflow, underflow and div_by_zero all 0. A reset mid-operation aborts the operation immediately; no done pulse follows.
- States: IDLE, DIVIDE, NORM, DONE.
- IDLE, start=1:
  - Register A and B, sign = A[31]^B[31].
  - Classify operands. An exponent of 0 means zero; denormals are flushed to zero. An exponent of FF means exception.
  - Special case -> NORM. Otherwise load mA = {1,A[22:0]}, mB = {1,B[22:0]}, remainder = mA, count = 0, then go to DIVIDE.
- DIVIDE, each cycle:
  - trial = remainder - mB.
  - If trial >= 0: shift a 1 into q and set remainder = trial << 1.
  - Else: shift a 0 into q and set remainder = remainder << 1.
  - Exactly 25 iterations (count 0..24), giving q[24:0] = floor(mA*2^24 / mB). Then go to NORM.
- NORM:
  - If q[24]=1: frac = q[23:1], e = eA - eB + 127.
  - Else: frac = q[22:0], e = eA - eB + 126.
  - e is computed as a 10-bit signed value; zero-extend both exponents before subtracting.
  - Rounding is truncation (round toward zero), consistent with the multiplier.
  - Next state: DONE.
- Result priority in NORM (registered into the outputs):
  1. exception: quot = 0.
  2. div_by_zero: quot = {sign, 8'hFF, 23'd0}.
  3. A zero: quot = {sign, 31'd0}.
  4. overflow (e >= 255): quot = {sign, 8'hFF, 23'd0}.
  5. underflow (e <= 0): quot = {sign, 31'd0}.
  6. Otherwise: quot = {sign, e[7:0], frac}.
- Only the flag of the selected case is set; all other flags are 0.
- DONE: done=1 for exactly one cycle, then go to IDLE.
- Outputs: quot and all flags hold their values until the next accepted start. Flags clear at acceptance.
- Latency, with start accepted at edge T0:
  - Normal operands: done is high in the cycle after edge T0+26; busy=0 after edge T0+27.
  - Special cases skip DIVIDE: done is high after edge T0+1.
- Handshake:
  - start is ignored while busy=1, including in the DONE cycle.
  - Changes on A and B after acceptance have no effect.
  - Back-to-back throughput: one operation per 28 cycles (normal case).

Test Plan:
- A=0x40400000 (3.0), B=0x3FC00000 (1.5) -> quot=0x40000000, all flags 0, done exactly 26 cycles after the start edge.
- A=0x3F800000 (1.0), B=0x40400000 (3.0) -> quot=0x3EAAAAAA (truncated); A=0xBF800000, B=0x3F800000 -> quot=0xBF800000.
- A=0xC0000000, B=0x00000000 -> quot=0xFF800000, div_by_zero=1, done 1 cycle after start; A=0, B=0 -> exception=1, quot=0; A=0x80000000, B=0x40000000 -> quot=0x80000000.
- A=0x7F000000, B=0x00800000 -> overflow=1, quot=0x7F800000; A=0x00800000, B=0x7F000000 -> underflow=1, quot=0x00000000; A=0x7F800000, B=0x3F800000 -> exception=1, quot=0.
- Handshake: pulse start again at T0+5 with different operands -> ignored, the first result is delivered; A/B toggled during DIVIDE -> result unchanged; start held high continuously -> one operation per 28 cycles.
- Reset asserted at T0+10 -> the next cycle shows busy=0, done=0, quot=0, all flags 0; no done pulse follows; a new start afterwards completes normally.
